// File: rtl/programmable_clock_divider_if.sv
// Control and status bundle for the programmable clock divider.
// The master side programs and enables the divider; the slave side is the divider itself.
interface programmable_clock_divider_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 div_load;
  logic [CNT_WIDTH-1:0] div_value;
  logic [CNT_WIDTH-1:0] high_value;
  logic                 clockOUT;
  logic                 tick;
  logic                 running;
  logic                 pending;
  logic                 load_done;
  logic                 load_err;
  logic [CNT_WIDTH-1:0] cur_div;

  modport master (
    output enable, div_load, div_value, high_value,
    input  clockOUT, tick, running, pending, load_done, load_err, cur_div
  );

  modport slave (
    input  enable, div_load, div_value, high_value,
    output clockOUT, tick, running, pending, load_done, load_err, cur_div
  );
endinterface

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock divider with glitch-free start/stop, shadowed
// period/high-time programming applied only on period boundaries, and a per-period tick.
module programmable_clock_divider #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input logic                clockIN,
  input logic                resetN,
  programmable_clock_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} stateT;

  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DEF_H = CNT_WIDTH'(DEFAULT_DIV / 2);

  stateT                state;
  stateT                nextState;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] periodReg;
  logic [CNT_WIDTH-1:0] highReg;
  logic [CNT_WIDTH-1:0] shadowP;
  logic [CNT_WIDTH-1:0] shadowH;
  logic [CNT_WIDTH-1:0] hEff;
  logic                 pendingReg;
  logic                 clockReg;
  logic                 tickReg;
  logic                 loadDoneReg;
  logic                 loadErrReg;
  logic                 atLast;
  logic                 countEdge;
  logic                 wrap;
  logic                 loadLegal;
  logic                 applyNow;

  // The IDLE->RUN edge already counts, so clockOUT rises on the enabling edge.
  assign atLast    = (count == periodReg - ONE);
  assign countEdge = (state != IDLE) || bus.enable;
  assign wrap      = countEdge && atLast;
  assign loadLegal = bus.div_load && (bus.div_value >= TWO);
  assign applyNow  = pendingReg && (wrap || (state == IDLE));

  always_comb begin
    hEff = bus.high_value;
    if (bus.high_value == '0) begin
      hEff = bus.div_value >> 1;
    end else if (bus.high_value >= bus.div_value) begin
      hEff = bus.div_value - ONE;
    end
  end

  always_ff @(posedge clockIN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Stopping always runs the current period to its wrap so no runt pulse escapes.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.enable) nextState = RUN;
      end
      RUN: begin
        if (!bus.enable) nextState = atLast ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (bus.enable) nextState = RUN;
        else if (atLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clockIN) begin
    if (!resetN) begin
      count       <= '0;
      periodReg   <= DEF_P;
      highReg     <= DEF_H;
      shadowP     <= '0;
      shadowH     <= '0;
      pendingReg  <= 1'b0;
      clockReg    <= 1'b0;
      tickReg     <= 1'b0;
      loadDoneReg <= 1'b0;
      loadErrReg  <= 1'b0;
    end else begin
      loadDoneReg <= applyNow;
      loadErrReg  <= bus.div_load && !loadLegal;
      if (countEdge) begin
        clockReg <= (count < highReg);
        tickReg  <= (count == '0);
        count    <= atLast ? '0 : count + ONE;
      end else begin
        clockReg <= 1'b0;
        tickReg  <= 1'b0;
        count    <= '0;
      end
      if (applyNow) begin
        periodReg <= shadowP;
        highReg   <= shadowH;
      end
      // A load landing on the apply edge refills the shadow and stays pending.
      if (loadLegal) begin
        shadowP    <= bus.div_value;
        shadowH    <= hEff;
        pendingReg <= 1'b1;
      end else if (applyNow) begin
        pendingReg <= 1'b0;
      end
    end
  end

  assign bus.clockOUT  = clockReg;
  assign bus.tick      = tickReg;
  assign bus.running   = (state != IDLE);
  assign bus.pending   = pendingReg;
  assign bus.load_done = loadDoneReg;
  assign bus.load_err  = loadErrReg;
  assign bus.cur_div   = periodReg;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench: directed scenarios against fixed waveforms, then randomized
// enable/load/reset traffic against a period-position reference model.
module tb_programmable_clock_divider;

  localparam int CW          = 16;
  localparam int DEFAULT_DIV = 2;

  logic clockIN = 1'b0;
  logic resetN  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  programmable_clock_divider_if #(.CNT_WIDTH(CW)) bus ();

  programmable_clock_divider #(
    .CNT_WIDTH  (CW),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clockIN(clockIN),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clockIN = ~clockIN;

  task automatic step();
    @(posedge clockIN);
    #1;
  endtask

  task automatic setLoad(input logic ld, input int dv, input int hv);
    bus.div_load   = ld;
    bus.div_value  = CW'(dv);
    bus.high_value = CW'(hv);
  endtask

  task automatic doReset();
    resetN     = 1'b0;
    bus.enable = 1'b0;
    setLoad(1'b0, 0, 0);
    step();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.clockOUT !== 1'b0) begin errors++; $display("[TB] FAIL reset_clockOUT got %b want 0", bus.clockOUT); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", bus.tick); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %b want 0", bus.running); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0", bus.pending); end
    checks++; if (bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got done=%b err=%b want 0,0", bus.load_done, bus.load_err); end
    checks++; if (bus.cur_div !== CW'(DEFAULT_DIV)) begin errors++; $display("[TB] FAIL reset_cur_div got %0d want %0d", bus.cur_div, DEFAULT_DIV); end
  endtask

  task automatic test_default_div();
    doReset();
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.clockOUT !== ((i % 2) == 0)) begin errors++; $display("[TB] FAIL default_clockOUT edge %0d got %b want %b", i, bus.clockOUT, (i % 2) == 0); end
      checks++; if (bus.tick !== ((i % 2) == 0)) begin errors++; $display("[TB] FAIL default_tick edge %0d got %b want %b", i, bus.tick, (i % 2) == 0); end
    end
  endtask

  task automatic test_load_idle();
    doReset();
    setLoad(1'b1, 5, 0);
    step();
    setLoad(1'b0, 0, 0);
    checks++; if (bus.pending !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL idle_load_pending got p=%b d=%b want 1,0", bus.pending, bus.load_done); end
    bus.enable = 1'b1;
    step();
    checks++; if (bus.load_done !== 1'b1 || bus.cur_div !== CW'(5) || bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL idle_load_apply got d=%b p=%b cur=%0d want 1,0,5", bus.load_done, bus.pending, bus.cur_div); end
    for (int pos = 0; pos < 10; pos++) begin
      if (pos != 0) step();
      checks++; if (bus.clockOUT !== ((pos % 5) < 2)) begin errors++; $display("[TB] FAIL idle_load_wave pos %0d got %b want %b", pos, bus.clockOUT, (pos % 5) < 2); end
    end
  endtask

  task automatic test_midperiod_load();
    doReset();
    setLoad(1'b1, 4, 0);
    step();
    setLoad(1'b0, 0, 0);
    bus.enable = 1'b1;
    step();
    step();
    setLoad(1'b1, 7, 6);
    step();
    setLoad(1'b0, 0, 0);
    checks++; if (bus.pending !== 1'b1 || bus.cur_div !== CW'(4) || bus.clockOUT !== 1'b0) begin errors++; $display("[TB] FAIL mid_load_pending got p=%b cur=%0d clk=%b want 1,4,0", bus.pending, bus.cur_div, bus.clockOUT); end
    step();
    checks++; if (bus.load_done !== 1'b1 || bus.cur_div !== CW'(7) || bus.clockOUT !== 1'b0) begin errors++; $display("[TB] FAIL mid_load_apply got d=%b cur=%0d clk=%b want 1,7,0", bus.load_done, bus.cur_div, bus.clockOUT); end
    for (int pos = 0; pos < 7; pos++) begin
      step();
      checks++; if (bus.clockOUT !== (pos < 6) || bus.tick !== (pos == 0)) begin errors++; $display("[TB] FAIL mid_load_wave pos %0d got clk=%b tick=%b want %b,%b", pos, bus.clockOUT, bus.tick, pos < 6, pos == 0); end
    end
  endtask

  task automatic test_stop();
    doReset();
    setLoad(1'b1, 6, 0);
    step();
    setLoad(1'b0, 0, 0);
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    for (int pos = 1; pos < 6; pos++) begin
      step();
      checks++; if (bus.clockOUT !== (pos < 3) || bus.running !== (pos != 5)) begin errors++; $display("[TB] FAIL stop_wave pos %0d got clk=%b run=%b want %b,%b", pos, bus.clockOUT, bus.running, pos < 3, pos != 5); end
    end
    step();
    checks++; if (bus.clockOUT !== 1'b0 || bus.running !== 1'b0 || bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL stop_idle got clk=%b run=%b tick=%b want 0,0,0", bus.clockOUT, bus.running, bus.tick); end
  endtask

  task automatic test_load_err();
    doReset();
    setLoad(1'b1, 1, 0);
    step();
    setLoad(1'b0, 0, 0);
    checks++; if (bus.load_err !== 1'b1 || bus.cur_div !== CW'(DEFAULT_DIV) || bus.pending !== 1'b0) begin errors++; $display("[TB] FAIL load_err_pulse got e=%b cur=%0d p=%b want 1,2,0", bus.load_err, bus.cur_div, bus.pending); end
    step();
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("[TB] FAIL load_err_clear got %b want 0", bus.load_err); end
    setLoad(1'b1, 4, 9);
    step();
    setLoad(1'b0, 0, 0);
    bus.enable = 1'b1;
    step();
    checks++; if (bus.cur_div !== CW'(4) || bus.clockOUT !== 1'b1) begin errors++; $display("[TB] FAIL clamp_apply got cur=%0d clk=%b want 4,1", bus.cur_div, bus.clockOUT); end
    for (int pos = 1; pos < 8; pos++) begin
      step();
      checks++; if (bus.clockOUT !== ((pos % 4) < 3)) begin errors++; $display("[TB] FAIL clamp_wave pos %0d got %b want %b", pos, bus.clockOUT, (pos % 4) < 3); end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    setLoad(1'b1, 8, 0);
    step();
    setLoad(1'b0, 0, 0);
    bus.enable = 1'b1;
    step();
    step();
    setLoad(1'b1, 3, 0);
    step();
    setLoad(1'b0, 0, 0);
    resetN = 1'b0;
    step();
    checks++; if (bus.clockOUT !== 1'b0 || bus.cur_div !== CW'(DEFAULT_DIV) || bus.pending !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid got clk=%b cur=%0d p=%b run=%b want 0,2,0,0", bus.clockOUT, bus.cur_div, bus.pending, bus.running); end
    resetN = 1'b1;
  endtask

  task automatic test_back_to_back();
    int doneCount;
    int doneAt;
    doReset();
    setLoad(1'b1, 8, 0);
    step();
    setLoad(1'b0, 0, 0);
    bus.enable = 1'b1;
    step();
    step();
    setLoad(1'b1, 3, 0);
    step();
    setLoad(1'b1, 5, 0);
    step();
    setLoad(1'b0, 0, 0);
    checks++; if (bus.pending !== 1'b1 || bus.cur_div !== CW'(8)) begin errors++; $display("[TB] FAIL b2b_pending got p=%b cur=%0d want 1,8", bus.pending, bus.cur_div); end
    doneCount = 0;
    doneAt    = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.load_done === 1'b1) begin
        doneCount++;
        if (doneAt < 0) doneAt = i;
      end
    end
    checks++; if (doneCount != 1 || doneAt != 3) begin errors++; $display("[TB] FAIL b2b_done got count=%0d at=%0d want 1 at 3", doneCount, doneAt); end
    checks++; if (bus.cur_div !== CW'(5)) begin errors++; $display("[TB] FAIL b2b_last_wins got %0d want 5", bus.cur_div); end
  endtask

  task automatic test_random();
    int mPos, mP, mH, sP, sH, dv, hv;
    bit mRun, mPend, en, ld, rst;
    bit eClk, eTick, eDone, eErr, wasIdle, endP;
    doReset();
    mPos = 0; mP = DEFAULT_DIV; mH = DEFAULT_DIV / 2; sP = 0; sH = 0;
    mRun = 0; mPend = 0; en = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 11) == 0) en = !en;
      ld = ($urandom_range(0, 5) == 0);
      dv = $urandom_range(0, 9);
      hv = $urandom_range(0, 11);
      resetN     = !rst;
      bus.enable = en;
      setLoad(ld, dv, hv);
      step();
      eClk = 0; eTick = 0; eDone = 0; eErr = 0;
      if (rst) begin
        mPos = 0; mP = DEFAULT_DIV; mH = DEFAULT_DIV / 2; mRun = 0; mPend = 0;
      end else begin
        wasIdle = !mRun;
        endP    = 0;
        if (mRun || en) begin
          eClk  = (mPos < mH);
          eTick = (mPos == 0);
          endP  = (mPos == mP - 1);
          mPos  = endP ? 0 : mPos + 1;
          if (en) mRun = 1;
          else if (endP) mRun = 0;
        end
        if (mPend && (wasIdle || endP)) begin
          mP = sP; mH = sH; mPend = 0; eDone = 1;
        end
        if (ld) begin
          if (dv < 2) eErr = 1;
          else begin
            sP = dv;
            sH = (hv == 0) ? dv / 2 : ((hv > dv - 1) ? dv - 1 : hv);
            mPend = 1;
          end
        end
      end
      checks++; if (bus.clockOUT !== eClk) begin errors++; $display("[TB] FAIL rand_clockOUT cyc %0d got %b want %b", cyc, bus.clockOUT, eClk); end
      checks++; if (bus.tick !== eTick) begin errors++; $display("[TB] FAIL rand_tick cyc %0d got %b want %b", cyc, bus.tick, eTick); end
      checks++; if (bus.running !== mRun) begin errors++; $display("[TB] FAIL rand_running cyc %0d got %b want %b", cyc, bus.running, mRun); end
      checks++; if (bus.pending !== mPend) begin errors++; $display("[TB] FAIL rand_pending cyc %0d got %b want %b", cyc, bus.pending, mPend); end
      checks++; if (bus.load_done !== eDone) begin errors++; $display("[TB] FAIL rand_load_done cyc %0d got %b want %b", cyc, bus.load_done, eDone); end
      checks++; if (bus.load_err !== eErr) begin errors++; $display("[TB] FAIL rand_load_err cyc %0d got %b want %b", cyc, bus.load_err, eErr); end
      checks++; if (bus.cur_div !== CW'(mP)) begin errors++; $display("[TB] FAIL rand_cur_div cyc %0d got %0d want %0d", cyc, bus.cur_div, mP); end
    end
    resetN = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0;
    setLoad(1'b0, 0, 0);
    $display("[TB] starting programmable_clock_divider bench");
    test_reset();
    test_default_div();
    test_load_idle();
    test_midperiod_load();
    test_stop();
    test_load_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
